// File: rtl/busca_instrucao.sv
// Instruction fetch stage: issues fetch requests at the current PC, tracks
// in-flight requests, drops responses made stale by a redirect, and presents
// returned instructions through a show-ahead FIFO to decode.
module busca_instrucao #(
  parameter int PROFUNDIDADE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] endereco_atual,
  input  logic        halt,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic        mem_valido,
  input  logic [31:0] mem_dado,
  output logic        parar_pc,
  output logic        instr_valida,
  output logic [31:0] instrucao,
  output logic [31:0] instr_endereco,
  input  logic        consumir,
  output logic        erro_protocolo
);

  localparam int              CW     = $clog2(PROFUNDIDADE + 1);
  localparam int              PW     = $clog2(PROFUNDIDADE);
  localparam logic [CW:0]     LIMITE = (CW + 1)'(PROFUNDIDADE);
  localparam logic [PW-1:0]   ULTIMO = PW'(PROFUNDIDADE - 1);

  // Buffered entries, accepted-but-unanswered requests, and how many of
  // those unanswered requests belong to a path abandoned by a flush.
  logic [CW-1:0] ocupacao;
  logic [CW-1:0] pendentes;
  logic [CW-1:0] descarte;

  logic [PW-1:0] fila_rd;
  logic [PW-1:0] fila_wr;
  logic [PW-1:0] pend_rd;
  logic [PW-1:0] pend_wr;

  logic [31:0] pend_addr  [PROFUNDIDADE];
  logic [31:0] fifo_instr [PROFUNDIDADE];
  logic [31:0] fifo_addr  [PROFUNDIDADE];

  logic aceita;
  logic resposta;
  logic descarta;
  logic grava;
  logic retira;

  // Pointers wrap at the buffer depth, which need not be a power of two.
  function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
    return (p == ULTIMO) ? '0 : p + PW'(1);
  endfunction

  // Outstanding fetches reserve buffer slots, so a request is only issued
  // when every in-flight response is guaranteed a place to land.
  assign mem_endereco = endereco_atual;
  assign mem_req      = reset && !halt && !flush &&
                        (({1'b0, ocupacao} + {1'b0, pendentes}) < LIMITE);
  assign aceita       = mem_req && mem_pronto;
  assign parar_pc     = !aceita;

  // A response is matched to the oldest pending request; stale ones and any
  // arriving during a flush never reach the buffer.
  assign resposta     = mem_valido && (pendentes != '0);
  assign descarta     = mem_valido && (descarte != '0);
  assign grava        = resposta && !descarta && !flush;

  // Show-ahead head; an empty buffer presents zeros rather than stale data.
  assign instr_valida   = (ocupacao != '0);
  assign retira         = consumir && instr_valida && !flush;
  assign instrucao      = instr_valida ? fifo_instr[fila_rd] : '0;
  assign instr_endereco = instr_valida ? fifo_addr[fila_rd]  : '0;

  // Counters, pointers and the sticky protocol error flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocupacao       <= '0;
      pendentes      <= '0;
      descarte       <= '0;
      fila_rd        <= '0;
      fila_wr        <= '0;
      pend_rd        <= '0;
      pend_wr        <= '0;
      erro_protocolo <= 1'b0;
    end else begin
      if (aceita)   pend_wr <= avanca(pend_wr);
      if (resposta) pend_rd <= avanca(pend_rd);
      pendentes <= pendentes + CW'(aceita) - CW'(resposta);

      // No request is accepted while flush is high, so every request still
      // unanswered after this edge belongs to the abandoned path.
      if (flush) begin
        descarte <= pendentes - CW'(resposta);
      end else if (descarta) begin
        descarte <= descarte - CW'(1);
      end

      if (flush) begin
        ocupacao <= '0;
        fila_rd  <= fila_wr;
      end else begin
        if (grava)  fila_wr <= avanca(fila_wr);
        if (retira) fila_rd <= avanca(fila_rd);
        ocupacao <= ocupacao + CW'(grava) - CW'(retira);
      end

      if (mem_valido && (pendentes == '0)) erro_protocolo <= 1'b1;
    end
  end

  // Pending-address queue and instruction buffer storage.
  // NOTE: storage arrays carry no reset; the counters and pointers alone
  // decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (aceita) pend_addr[pend_wr] <= endereco_atual;
    if (grava) begin
      fifo_instr[fila_wr] <= mem_dado;
      fifo_addr[fila_wr]  <= pend_addr[pend_rd];
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: a queue-based reference model of
// the pending requests and the instruction buffer, a memory responder with
// one-cycle latency, a table of combinational request vectors, and directed
// sequences for streaming, backpressure, flush, halt, spurious response and reset.
module tb_busca_instrucao;

  localparam int P = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  typedef struct {
    logic        halt;
    logic        flush;
    logic        pronto;
    logic [31:0] pc;
    logic        req;
    logic        parar;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [31:0] endereco_atual;
  logic        halt;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_pronto;
  logic        mem_valido;
  logic [31:0] mem_dado;
  logic        parar_pc;
  logic        instr_valida;
  logic [31:0] instrucao;
  logic [31:0] instr_endereco;
  logic        consumir;
  logic        erro_protocolo;

  busca_instrucao #(.PROFUNDIDADE(P)) dut (
    .clock          (clock),
    .reset          (reset),
    .endereco_atual (endereco_atual),
    .halt           (halt),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_endereco   (mem_endereco),
    .mem_pronto     (mem_pronto),
    .mem_valido     (mem_valido),
    .mem_dado       (mem_dado),
    .parar_pc       (parar_pc),
    .instr_valida   (instr_valida),
    .instrucao      (instrucao),
    .instr_endereco (instr_endereco),
    .consumir       (consumir),
    .erro_protocolo (erro_protocolo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  item_t       exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] popped[$];
  int          disc = 0;
  logic        err = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] flush_target = '0;
  int          mem_mode = 0;   // 0 auto respond, 1 hold responses, 2 manual
  int          dut_acc = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock cycle: drive PC and memory, compare outputs against the model,
  // cross the edge, then advance the model.
  task automatic tick();
    logic  exp_req;
    logic  exp_acc;
    logic  do_pop;
    item_t it;
    endereco_atual = pc;
    if (mem_mode == 0) begin
      mem_valido = (mem_q.size() > 0);
      mem_dado   = mem_valido ? data_of(mem_q[0]) : '0;
    end else if (mem_mode == 1) begin
      mem_valido = 1'b0;
      mem_dado   = '0;
    end
    #2;
    exp_req = !halt && !flush && ((exp_q.size() + pend_q.size()) < P);
    exp_acc = exp_req && mem_pronto;
    check("mem_req", mem_req, exp_req);
    check("parar_pc", parar_pc, !exp_acc);
    check("mem_endereco", mem_endereco, pc);
    check("instr_valida", instr_valida, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("instrucao", instrucao, exp_q[0].data);
      check("instr_endereco", instr_endereco, exp_q[0].addr);
    end
    check("erro_protocolo", erro_protocolo, err);
    do_pop = consumir && (exp_q.size() > 0) && !flush;
    if (consumir && instr_valida) popped.push_back(instr_endereco);
    if (mem_req && mem_pronto) dut_acc++;
    @(posedge clock);
    #1;
    if (do_pop) void'(exp_q.pop_front());
    if (mem_valido) begin
      if (mem_mode == 0) void'(mem_q.pop_front());
      if (disc > 0) begin
        disc--;
        void'(pend_q.pop_front());
      end else if (pend_q.size() > 0) begin
        it.addr = pend_q.pop_front();
        it.data = mem_dado;
        if (!flush) exp_q.push_back(it);
      end else begin
        err = 1'b1;
      end
    end
    if (flush) begin
      exp_q.delete();
      disc = pend_q.size();
      pc   = flush_target;
    end
    if (exp_acc) begin
      pend_q.push_back(pc);
      mem_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  task automatic drain();
    halt     = 1'b1;
    consumir = 1'b1;
    mem_mode = 0;
    repeat (6) tick();
    consumir = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] b1;
    bit          found;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1};

    reset          = 1'b0;
    halt           = 1'b0;
    flush          = 1'b0;
    consumir       = 1'b0;
    mem_pronto     = 1'b0;
    mem_valido     = 1'b0;
    mem_dado       = '0;
    endereco_atual = 32'h1234_5678;

    // Reset state, with halt low so the reset gating on mem_req is visible.
    #3;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_parar_pc", parar_pc, 1'b1);
    check("rst_instr_valida", instr_valida, 1'b0);
    check("rst_instrucao", instrucao, 32'h0);
    check("rst_instr_endereco", instr_endereco, 32'h0);
    check("rst_erro", erro_protocolo, 1'b0);

    @(posedge clock);
    #1;
    reset = 1'b1;

    // Combinational request gating from the idle state, all within one cycle.
    for (int i = 0; i < 8; i++) begin
      halt           = vecs[i].halt;
      flush          = vecs[i].flush;
      mem_pronto     = vecs[i].pronto;
      endereco_atual = vecs[i].pc;
      #1;
      check($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].req);
      check($sformatf("vec%0d_parar_pc", i), parar_pc, vecs[i].parar);
      check($sformatf("vec%0d_mem_endereco", i), mem_endereco, vecs[i].pc);
    end
    halt       = 1'b1;
    flush      = 1'b0;
    mem_pronto = 1'b0;
    @(posedge clock);
    #1;

    // Streaming from PC 0 with one-cycle memory latency.
    pc         = '0;
    halt       = 1'b0;
    mem_pronto = 1'b1;
    consumir   = 1'b1;
    mem_mode   = 0;
    popped.delete();
    repeat (14) tick();
    check("stream_pop_count", popped.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++)
      check($sformatf("stream_addr%0d", i),
            (i < popped.size()) ? popped[i] : 32'hFFFF_FFFF, 32'(i * 4));
    drain();

    // Backpressure: without consumption only P requests go out.
    halt     = 1'b0;
    consumir = 1'b0;
    dut_acc  = 0;
    repeat (6) tick();
    check("bp_accepts", dut_acc, 32'd2);
    check("bp_mem_req_held", mem_req, 1'b0);
    check("bp_parar_pc_held", parar_pc, 1'b1);
    consumir = 1'b1;
    tick();
    consumir = 1'b0;
    check("bp_resume", mem_req, 1'b1);
    drain();

    // Flush with two requests in flight, PC redirected to 0x100.
    halt         = 1'b0;
    consumir     = 1'b0;
    mem_mode     = 1;
    tick();
    tick();
    flush        = 1'b1;
    flush_target = 32'h0000_0100;
    tick();
    flush    = 1'b0;
    mem_mode = 0;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valida) found = 1'b1;
      else tick();
    end
    check("flush_valid_seen", found, 1'b1);
    check("flush_first_addr", instr_endereco, 32'h0000_0100);
    check("flush_first_instr", instrucao, data_of(32'h0000_0100));
    drain();

    // Push, pop and halt together with one entry buffered.
    halt     = 1'b0;
    consumir = 1'b0;
    mem_mode = 0;
    tick();
    b1 = pc;
    tick();
    halt     = 1'b1;
    consumir = 1'b1;
    tick();
    consumir = 1'b0;
    check("pph_valid", instr_valida, 1'b1);
    check("pph_head_addr", instr_endereco, b1);
    check("pph_head_instr", instrucao, data_of(b1));

    // Spurious response with nothing in flight leaves the buffer untouched.
    mem_mode   = 2;
    mem_valido = 1'b1;
    mem_dado   = 32'hBAD0_BAD0;
    tick();
    mem_valido = 1'b0;
    check("spur_erro", erro_protocolo, 1'b1);
    check("spur_valid", instr_valida, 1'b1);
    check("spur_head_addr", instr_endereco, b1);
    check("spur_head_instr", instrucao, data_of(b1));
    drain();

    // Asynchronous reset in the middle of streaming.
    halt     = 1'b0;
    consumir = 1'b1;
    mem_mode = 0;
    repeat (5) tick();
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_parar_pc", parar_pc, 1'b1);
    check("mid_rst_instr_valida", instr_valida, 1'b0);
    check("mid_rst_instrucao", instrucao, 32'h0);
    check("mid_rst_instr_endereco", instr_endereco, 32'h0);
    check("mid_rst_erro", erro_protocolo, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    pend_q.delete();
    mem_q.delete();
    disc = 0;
    err  = 1'b0;

    // A late response to an abandoned request counts as a protocol error.
    halt       = 1'b1;
    consumir   = 1'b0;
    mem_mode   = 2;
    mem_valido = 1'b1;
    mem_dado   = 32'h0BAD_CAFE;
    tick();
    mem_valido = 1'b0;
    check("late_resp_erro", erro_protocolo, 1'b1);
    check("late_resp_valid", instr_valida, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
